// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared types and constants for the ALU-sharing arbiter.
package alu_share_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response handshake bundle for two requesters.
interface alu_share_arbiter_if #(parameter int WIDTH = 4);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [3:0]         req_ctrl;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [WIDTH-1:0]   resp_result;
    logic [3:0]         resp_nzcv;
    modport master (
        output req_valid, req_a, req_b, req_ctrl, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_nzcv
    );
    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, resp_ready,
        output req_ready, resp_valid, resp_result, resp_nzcv
    );
endinterface

// File: rtl/alu_nzcv.sv
// alu_nzcv: combinational add/sub/and/or ALU with NZCV flags (C on sub = no borrow).
module alu_nzcv import alu_share_pkg::*; #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c;
    logic           v;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = ctrl == ALU_ADD ? sum[WIDTH-1:0] :
                 ctrl == ALU_SUB ? diff[WIDTH-1:0] :
                 ctrl == ALU_AND ? (a & b) : (a | b);
        c = ctrl == ALU_ADD ? sum[WIDTH] : ctrl == ALU_SUB ? ~diff[WIDTH] : 1'b0;
        v = ctrl == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) :
            ctrl == ALU_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]) : 1'b0;
        nzcv = '0;
        nzcv[NZCV_N] = result[WIDTH-1];
        nzcv[NZCV_Z] = ~|result;
        nzcv[NZCV_C] = c;
        nzcv[NZCV_V] = v;
    end
endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       id
);
    assign grant = &req ? (last_grant ? 2'b01 : 2'b10) : req;
    assign id    = grant[1];
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one alu_nzcv between two valid/ready requesters,
// with registered operands before the ALU and registered result/flags after it.
module alu_share_arbiter import alu_share_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    alu_share_arbiter_if.slave     bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       ops_done
);
    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             id;
    logic [1:0]       grant;
    logic             gid;
    logic             accept;
    logic             done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_nzcv_flags;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzcv_q;

    rr_arbiter2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .id         (gid)
    );

    alu_nzcv #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctrl   (op_ctrl),
        .result (alu_result),
        .nzcv   (alu_nzcv_flags)
    );

    // req_ready is gated by reset_n so it reads 0 while reset is held, even with requests pending
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 2'b00;
        bus.resp_valid = 2'b00;
        accept         = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = reset_n ? grant : 2'b00;
                accept        = |grant;
                state_nxt     = accept ? EXEC : IDLE;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                bus.resp_valid = id ? 2'b10 : 2'b01;
                done           = bus.resp_ready[id];
                state_nxt      = done ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            result_q   <= '0;
            nzcv_q     <= '0;
            ops_done   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id         <= gid;
                last_grant <= gid;
                op_a       <= gid ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                op_b       <= gid ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                op_ctrl    <= gid ? bus.req_ctrl[3:2] : bus.req_ctrl[1:0];
            end
            if (state == EXEC) begin
                result_q <= alu_result;
                nzcv_q   <= alu_nzcv_flags;
            end
            if (done) ops_done <= ops_done + CNT_W'(1);
        end
    end

    assign bus.resp_result = result_q;
    assign bus.resp_nzcv   = nzcv_q;
    assign busy            = state != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with hand-computed results for the shared-ALU arbiter.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [7:0] ops_done;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_ops = 0;

    alu_share_arbiter_if #(.WIDTH(4)) bus ();

    alu_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .busy     (busy),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
        bus.req_a[r*4 +: 4]    = a;
        bus.req_b[r*4 +: 4]    = b;
        bus.req_ctrl[r*2 +: 2] = c;
        bus.req_valid[r]       = 1'b1;
    endtask

    // Grant g is expected now; walk accept -> EXEC -> RESP -> handshake
    task automatic serve(input logic [1:0] g, input logic [3:0] res, input logic [3:0] nzcv, input string tag);
        #1;
        chk({tag, "_ready"}, bus.req_ready, g);
        tick();
        bus.req_valid = bus.req_valid & ~g;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_exec_valid"}, bus.resp_valid, 0);
        tick();
        chk({tag, "_resp_valid"}, bus.resp_valid, g);
        chk({tag, "_result"}, bus.resp_result, res);
        chk({tag, "_nzcv"}, bus.resp_nzcv, nzcv);
        bus.resp_ready = g;
        tick();
        bus.resp_ready = 2'b00;
        exp_ops = (exp_ops + 1) % 256;
        chk({tag, "_idle_valid"}, bus.resp_valid, 0);
        chk({tag, "_ops"}, ops_done, exp_ops);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_ctrl   = '0;
        bus.resp_ready = 2'b00;
        set_req(0, 4'hF, 4'h3, ALU_AND);
        set_req(1, 4'h8, 4'h1, ALU_OR);
        #2;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_nzcv", bus.resp_nzcv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ops", ops_done, 0);
        tick();
        tick();
        reset_n = 1'b1;
        serve(2'b01, 4'd3, 4'b0000, "tie_r0");
        serve(2'b10, 4'd9, 4'b1000, "tie_r1");
        set_req(0, 4'd7, 4'd1, ALU_ADD);
        serve(2'b01, 4'd8, 4'b1001, "add7p1");
        set_req(0, 4'd15, 4'd1, ALU_ADD);
        set_req(1, 4'd5, 4'd5, ALU_SUB);
        serve(2'b10, 4'd0, 4'b0110, "sub5m5");
        serve(2'b01, 4'd0, 4'b0110, "add15p1");
        set_req(1, 4'd3, 4'd5, ALU_SUB);
        serve(2'b10, 4'd14, 4'b1000, "sub3m5");
        set_req(0, 4'd5, 4'd6, ALU_AND);
        set_req(1, 4'd0, 4'd0, ALU_OR);
        serve(2'b01, 4'd4, 4'b0000, "alt_r0");
        serve(2'b10, 4'd0, 4'b0100, "alt_r1");
        set_req(0, 4'd4, 4'd4, ALU_ADD);
        #1;
        chk("stall_ready", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        set_req(1, 4'hF, 4'hF, ALU_AND);
        tick();
        tick();
        bus.resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.resp_valid, 2'b01);
            chk("stall_result", bus.resp_result, 8);
            chk("stall_nzcv", bus.resp_nzcv, 4'b1001);
            chk("stall_ready_blk", bus.req_ready, 0);
            tick();
        end
        chk("stall_ops", ops_done, exp_ops);
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = 2'b00;
        exp_ops++;
        chk("stall_done_ops", ops_done, exp_ops);
        serve(2'b10, 4'hF, 4'b1000, "after_stall");
        set_req(0, 4'd2, 4'd3, ALU_ADD);
        #1;
        tick();
        bus.req_valid = 2'b00;
        set_req(0, 4'd2, 4'd3, ALU_ADD);
        set_req(1, 4'd1, 4'd1, ALU_ADD);
        reset_n = 1'b0;
        #1;
        exp_ops = 0;
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_valid", bus.resp_valid, 0);
        chk("mid_rst_result", bus.resp_result, 0);
        chk("mid_rst_nzcv", bus.resp_nzcv, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ops", ops_done, 0);
        tick();
        reset_n = 1'b1;
        serve(2'b01, 4'd5, 4'b0000, "post_rst_tie");
        bus.req_valid = 2'b00;
        for (int i = 0; i < 255; i++) begin
            set_req(0, 4'd2, 4'd3, ALU_ADD);
            serve(2'b01, 4'd5, 4'b0000, "wrap");
        end
        chk("ops_wrapped", ops_done, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
